// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: single-master STB/ACK register bus between CPU and timer_ctrl.
interface timer_ctrl_if;
    logic        STB;
    logic        WE;
    logic [2:0]  ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    modport master (output STB, WE, ADR_I, DAT_I, input DAT_O, ACK);
    modport slave  (input STB, WE, ADR_I, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled compare timer with match IRQ on an STB/ACK register bus.
// Define TIMER_CTRL_AUTORELOAD_EN to implement CTRL.ARL; otherwise every match is one-shot.
module timer_ctrl #(
    parameter logic [31:0] DEFAULT_PRESCALE = 32'd999999,
    parameter int          CNT_W            = 32
) (
    input  logic        clk,
    input  logic        reset,
    timer_ctrl_if.slave bus,
    output logic        IRQ
);
    typedef enum logic {B_IDLE, B_ACK} bus_state_t;
    typedef enum logic {STOPPED, RUNNING} tmr_state_t;

    bus_state_t       bstate, bnext;
    tmr_state_t       tstate, tnext;
    logic             ie, arl, match;
    logic [31:0]      prescale, pc, rdata;
    logic [CNT_W-1:0] compare, count;
    logic             acc, wr, wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_stat;
    logic             pc_hit, tick, hit, one_shot;

    assign acc      = bstate == B_IDLE && bus.STB;
    assign wr       = acc && bus.WE;
    assign wr_ctrl  = wr && bus.ADR_I == 3'd0;
    assign wr_pre   = wr && bus.ADR_I == 3'd1;
    assign wr_cmp   = wr && bus.ADR_I == 3'd2;
    assign wr_cnt   = wr && bus.ADR_I == 3'd3;
    assign wr_stat  = wr && bus.ADR_I == 3'd4;
    assign pc_hit   = tstate == RUNNING && pc == prescale;
    assign tick     = pc_hit && !wr_cnt;
    assign hit      = tick && count == compare;
    assign one_shot = hit && !arl;
    assign IRQ      = match && ie;
    assign bus.ACK  = bstate == B_ACK;

`ifdef TIMER_CTRL_AUTORELOAD_EN
    // Auto-reload enable bit
    always_ff @(posedge clk or posedge reset)
        if (reset) arl <= 1'b0;
        else if (wr_ctrl) arl <= bus.DAT_I[2];
`else
    assign arl = 1'b0;
`endif

    // Bus FSM state register
    always_ff @(posedge clk or posedge reset)
        if (reset) bstate <= B_IDLE;
        else bstate <= bnext;

    // Bus FSM next state: each accepted strobe gets exactly one ACK cycle
    always_comb begin
        bnext = B_IDLE;
        if (acc) bnext = B_ACK;
    end

    // Timer FSM state register (RUNNING is the EN bit)
    always_ff @(posedge clk or posedge reset)
        if (reset) tstate <= STOPPED;
        else tstate <= tnext;

    // Timer FSM next state: a one-shot match beats a concurrent EN=1 write
    always_comb begin
        tnext = tstate;
        if (one_shot) tnext = STOPPED;
        else if (wr_ctrl) tnext = bus.DAT_I[0] ? RUNNING : STOPPED;
    end

    // Read mux, zero-extending narrow registers to the 32-bit bus
    always_comb begin
        rdata = 32'd0;
        case (bus.ADR_I)
            3'd0: rdata = {29'd0, arl, ie, tstate == RUNNING};
            3'd1: rdata = prescale;
            3'd2: rdata = 32'(compare);
            3'd3: rdata = 32'(count);
            3'd4: rdata = {31'd0, match};
            default: rdata = 32'd0;
        endcase
    end

    // Registers, prescaler and tick counter; bus COUNT writes and match set take priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie       <= 1'b0;
            prescale <= DEFAULT_PRESCALE;
            compare  <= '1;
            count    <= '0;
            match    <= 1'b0;
            pc       <= 32'd0;
            bus.DAT_O <= 32'd0;
        end else begin
            if (wr_ctrl) ie <= bus.DAT_I[1];
            if (wr_pre) prescale <= bus.DAT_I;
            if (wr_cmp) compare <= bus.DAT_I[CNT_W-1:0];
            pc <= (tstate == RUNNING && tnext == RUNNING && !pc_hit) ? pc + 32'd1 : 32'd0;
            if (wr_cnt) count <= bus.DAT_I[CNT_W-1:0];
            else if (tick) count <= hit ? (arl ? '0 : count) : count + CNT_W'(1);
            if (hit) match <= 1'b1;
            else if (wr_stat && bus.DAT_I[0]) match <= 1'b0;
            if (acc && !bus.WE) bus.DAT_O <= rdata;
        end
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    int   checks = 0;
    int   errors = 0;

    timer_ctrl_if bus_if();
    timer_ctrl dut (.clk(clk), .reset(reset), .bus(bus_if), .IRQ(irq));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] adr, input logic [31:0] data);
        bus_if.STB = 1'b1; bus_if.WE = 1'b1; bus_if.ADR_I = adr; bus_if.DAT_I = data;
        step();
        bus_if.STB = 1'b0; bus_if.WE = 1'b0;
        step();
    endtask

    task automatic bus_read(input logic [2:0] adr, output logic [31:0] data, output logic a1, output logic a2);
        bus_if.STB = 1'b1; bus_if.WE = 1'b0; bus_if.ADR_I = adr;
        step();
        data = bus_if.DAT_O; a1 = bus_if.ACK;
        bus_if.STB = 1'b0;
        step();
        a2 = bus_if.ACK;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [8];
        logic [31:0] d;
        logic a1, a2;
        exp_v = '{32'd0, 32'd999999, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        bus_if.STB = 1'b0; bus_if.WE = 1'b0; bus_if.ADR_I = 3'd0; bus_if.DAT_I = 32'd0;
        reset = 1'b1;
        repeat (3) step();
        checks++; if (bus_if.ACK !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", bus_if.ACK); end
        checks++; if (bus_if.DAT_O !== 32'd0) begin errors++; $display("FAIL rst_dato got %h exp 0", bus_if.DAT_O); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), d, a1, a2);
            checks++; if (d !== exp_v[i]) begin errors++; $display("FAIL rst_read[%0d] got %h exp %h", i, d, exp_v[i]); end
            checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL rst_ack_len[%0d] got %b%b exp 10", i, a1, a2); end
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        logic a1, a2;
        logic [31:0] ec;
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd2);
        bus_write(3'd0, 32'b011);
        for (int k = 1; k <= 14; k++) begin
            ec = k < 4 ? 32'd0 : (k < 8 ? 32'd1 : 32'd2);
            checks++; if (dut.count !== ec) begin errors++; $display("FAIL os_count[%0d] got %h exp %h", k, dut.count, ec); end
            checks++; if (irq !== (k >= 12)) begin errors++; $display("FAIL os_irq[%0d] got %b exp %b", k, irq, k >= 12); end
            step();
        end
        bus_read(3'd0, d, a1, a2);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL os_ctrl got %h exp 2", d); end
        bus_read(3'd3, d, a1, a2);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL os_count_hold got %h exp 2", d); end
        bus_read(3'd4, d, a1, a2);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL os_status got %h exp 1", d); end
    endtask

`ifdef TIMER_CTRL_AUTORELOAD_EN
    task automatic test_autoreload();
        logic ei;
        bus_write(3'd1, 32'd0);
        bus_write(3'd2, 32'd4);
        bus_write(3'd3, 32'd0);
        bus_write(3'd4, 32'd1);
        bus_write(3'd0, 32'b111);
        for (int k = 1; k <= 11; k++) begin
            ei = (k >= 5 && k < 7) || k >= 10;
            checks++; if (dut.count !== 32'(k % 5)) begin errors++; $display("FAIL arl_count[%0d] got %h exp %h", k, dut.count, k % 5); end
            checks++; if (irq !== ei) begin errors++; $display("FAIL arl_irq[%0d] got %b exp %b", k, irq, ei); end
            if (k == 6) begin
                bus_if.STB = 1'b1; bus_if.WE = 1'b1; bus_if.ADR_I = 3'd4; bus_if.DAT_I = 32'd1;
            end
            if (k == 7) begin
                bus_if.STB = 1'b0; bus_if.WE = 1'b0;
            end
            step();
        end
        bus_write(3'd0, 32'd0);
    endtask
`else
    task automatic test_arl_disabled();
        logic [31:0] d;
        logic a1, a2;
        bus_write(3'd0, 32'b110);
        bus_read(3'd0, d, a1, a2);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL arl_off_ctrl got %h exp 2", d); end
        bus_write(3'd0, 32'd0);
    endtask
`endif

    task automatic test_wrap();
        logic [31:0] d;
        logic a1, a2;
        logic [31:0] ec;
        bus_write(3'd4, 32'd1);
        bus_write(3'd1, 32'd0);
        bus_write(3'd2, 32'd5);
        bus_write(3'd3, 32'hFFFFFFFF);
        bus_write(3'd0, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            ec = k <= 6 ? 32'(k - 1) : 32'd5;
            checks++; if (dut.count !== ec) begin errors++; $display("FAIL wrap_count[%0d] got %h exp %h", k, dut.count, ec); end
            checks++; if (dut.match !== (k >= 7)) begin errors++; $display("FAIL wrap_match[%0d] got %b exp %b", k, dut.match, k >= 7); end
            step();
        end
        bus_read(3'd0, d, a1, a2);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL wrap_ctrl got %h exp 0", d); end
    endtask

    task automatic test_count_collision();
        logic [31:0] d;
        logic a1, a2;
        bus_write(3'd4, 32'd1);
        bus_write(3'd2, 32'hFFFFFFFF);
        bus_write(3'd3, 32'd0);
        bus_write(3'd0, 32'd1);
        bus_if.STB = 1'b1; bus_if.WE = 1'b1; bus_if.ADR_I = 3'd3; bus_if.DAT_I = 32'd100;
        step();
        checks++; if (dut.count !== 32'd100) begin errors++; $display("FAIL coll_count got %h exp 100", dut.count); end
        bus_if.STB = 1'b0; bus_if.WE = 1'b0;
        step();
        checks++; if (dut.count !== 32'd101) begin errors++; $display("FAIL coll_next got %h exp 101", dut.count); end
        bus_write(3'd0, 32'd0);
        bus_read(3'd3, d, a1, a2);
        checks++; if (d !== 32'd102) begin errors++; $display("FAIL coll_stop got %h exp 102", d); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] d;
        logic a1, a2;
        bus_if.STB = 1'b1; bus_if.WE = 1'b1; bus_if.ADR_I = 3'd2; bus_if.DAT_I = 32'h1234;
        step();
        checks++; if (bus_if.ACK !== 1'b1) begin errors++; $display("FAIL mid_ack got %b exp 1", bus_if.ACK); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_if.ACK !== 1'b0) begin errors++; $display("FAIL mid_ack_drop got %b exp 0", bus_if.ACK); end
        bus_if.STB = 1'b0; bus_if.WE = 1'b0;
        step();
        reset = 1'b0;
        step();
        bus_read(3'd2, d, a1, a2);
        checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_compare got %h exp ffffffff", d); end
        bus_read(3'd1, d, a1, a2);
        checks++; if (d !== 32'd999999) begin errors++; $display("FAIL mid_prescale got %h exp 999999", d); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
`ifdef TIMER_CTRL_AUTORELOAD_EN
        test_autoreload();
`else
        test_arl_disabled();
`endif
        test_wrap();
        test_count_collision();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
